// File: rtl/matrix_sum_collector_if.sv
// rtl/matrix_sum_collector_if.sv - capture/stream bundle between adder, collector and consumer
//
// Purpose: groups the adder-side capture strobe and vector with the
// element-stream handshake to the narrow consumer.
// Signals:
//   inReady      capture strobe from the adder's outReady
//   sumIn        packed vector, element k at [k*(IN_WIDTH+1) +: IN_WIDTH+1]
//   collectReady collector is filling and can take a strobe
//   outValid     outData holds a valid element
//   outAccept    consumer ready
//   outData      signed element
//   outRow       vector index of outData
//   outCol       element index of outData
//   outLast      final element of the matrix
//   overflow     sticky: a strobe arrived while not filling
// Modports: slave = collector side, master = adder/consumer side.

interface matrix_sum_collector_if #(
    parameter int IN_WIDTH = 16,
    parameter int VEC_LEN  = 10,
    parameter int NUM_VECS = 11
);
    localparam int EW    = IN_WIDTH + 1;
    localparam int ROW_W = (NUM_VECS > 1) ? $clog2(NUM_VECS) : 1;
    localparam int COL_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;

    logic                     inReady;
    logic [VEC_LEN*EW-1:0]    sumIn;
    logic                     collectReady;
    logic                     outValid;
    logic                     outAccept;
    logic signed [EW-1:0]     outData;
    logic [ROW_W-1:0]         outRow;
    logic [COL_W-1:0]         outCol;
    logic                     outLast;
    logic                     overflow;

    modport master (
        output inReady, sumIn, outAccept,
        input  collectReady, outValid, outData, outRow, outCol, outLast, overflow
    );

    modport slave (
        input  inReady, sumIn, outAccept,
        output collectReady, outValid, outData, outRow, outCol, outLast, overflow
    );
endinterface

// File: rtl/matrix_sum_collector.sv
// rtl/matrix_sum_collector.sv - collect a matrix of adder result vectors, then stream it element-wise
//
// Purpose: single-bank collect-then-drain buffer. In FILL each inReady strobe
// stores one vector; after NUM_VECS vectors the block switches to DRAIN and
// emits the matrix row-major, one registered element per transferred beat.
// Ports:
//   clk     rising-edge clock
//   reset   asynchronous active-low reset
//   enable  global clock enable; low freezes all state
//   bus     matrix_sum_collector_if.slave (capture side + element stream)

module matrix_sum_collector #(
    parameter int IN_WIDTH = 16,
    parameter int VEC_LEN  = 10,
    parameter int NUM_VECS = 11
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    matrix_sum_collector_if.slave  bus
);
    localparam int EW    = IN_WIDTH + 1;
    localparam int ROW_W = (NUM_VECS > 1) ? $clog2(NUM_VECS) : 1;
    localparam int COL_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_VECS - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(VEC_LEN - 1);

    typedef enum logic {S_FILL, S_DRAIN} state_t;

    state_t             state, state_n;
    logic [ROW_W-1:0]   wr_idx, wr_idx_n;
    logic [ROW_W-1:0]   rd_row, rd_row_n;
    logic [COL_W-1:0]   rd_col, rd_col_n;
    logic               out_valid, out_valid_n;
    logic               out_last, out_last_n;
    logic [EW-1:0]      out_data, out_data_n;
    logic               overflow_q, overflow_n;
    logic               capture;

    logic [VEC_LEN*EW-1:0] mem [NUM_VECS];
    logic [VEC_LEN*EW-1:0] first_row;
    logic [ROW_W-1:0]      nxt_row;
    logic [COL_W-1:0]      nxt_col;
    int                    nxt_base;

    // With a single vector the row being written on the final capture edge
    // is also the row that must be presented next, so bypass the buffer.
    assign first_row = (NUM_VECS == 1) ? bus.sumIn : mem[0];

    // Row-major successor of the element currently presented.
    always_comb begin
        nxt_col = rd_col + 1'b1;
        nxt_row = rd_row;
        if (rd_col == LAST_COL) begin
            nxt_col = '0;
            nxt_row = rd_row + 1'b1;
        end
        nxt_base = int'(nxt_col) * EW;
    end

    always_comb begin
        state_n     = state;
        wr_idx_n    = wr_idx;
        rd_row_n    = rd_row;
        rd_col_n    = rd_col;
        out_valid_n = out_valid;
        out_last_n  = out_last;
        out_data_n  = out_data;
        overflow_n  = overflow_q;
        capture     = 1'b0;
        if (enable) begin
            case (state)
                S_FILL: begin
                    if (bus.inReady) begin
                        capture = 1'b1;
                        if (wr_idx == LAST_ROW) begin
                            wr_idx_n    = '0;
                            state_n     = S_DRAIN;
                            out_valid_n = 1'b1;
                            rd_row_n    = '0;
                            rd_col_n    = '0;
                            out_data_n  = first_row[EW-1:0];
                            out_last_n  = (LAST_ROW == '0) && (LAST_COL == '0);
                        end else begin
                            wr_idx_n = wr_idx + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    // A strobe here (including on the last beat) is dropped.
                    if (bus.inReady) begin
                        overflow_n = 1'b1;
                    end
                    if (out_valid && bus.outAccept) begin
                        if (out_last) begin
                            state_n     = S_FILL;
                            out_valid_n = 1'b0;
                            out_last_n  = 1'b0;
                            rd_row_n    = '0;
                            rd_col_n    = '0;
                        end else begin
                            rd_row_n   = nxt_row;
                            rd_col_n   = nxt_col;
                            out_data_n = mem[nxt_row][nxt_base +: EW];
                            out_last_n = (nxt_row == LAST_ROW) && (nxt_col == LAST_COL);
                        end
                    end
                end
                default: state_n = S_FILL;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_FILL;
            wr_idx     <= '0;
            rd_row     <= '0;
            rd_col     <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_data   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state      <= state_n;
            wr_idx     <= wr_idx_n;
            rd_row     <= rd_row_n;
            rd_col     <= rd_col_n;
            out_valid  <= out_valid_n;
            out_last   <= out_last_n;
            out_data   <= out_data_n;
            overflow_q <= overflow_n;
        end
    end

    // Buffer contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (capture) begin
            mem[wr_idx] <= bus.sumIn;
        end
    end

    assign bus.collectReady = (state == S_FILL);
    assign bus.outValid     = out_valid;
    assign bus.outData      = out_data;
    assign bus.outRow       = rd_row;
    assign bus.outCol       = rd_col;
    assign bus.outLast      = out_last;
    assign bus.overflow     = overflow_q;

endmodule

// File: tb/tb_matrix_sum_collector.sv
// tb/tb_matrix_sum_collector.sv - directed self-checking bench for matrix_sum_collector

module tb_matrix_sum_collector;
    logic clk;
    logic reset;
    logic enable;

    int checks = 0;
    int errors = 0;
    int exp_d[6];

    logic [16:0]  sb [11][10];
    logic [169:0] dvec;
    logic [16:0]  ed17;

    matrix_sum_collector_if #(.IN_WIDTH(4), .VEC_LEN(3), .NUM_VECS(2)) s();
    matrix_sum_collector_if #(.IN_WIDTH(16), .VEC_LEN(10), .NUM_VECS(11)) d();

    matrix_sum_collector #(.IN_WIDTH(4), .VEC_LEN(3), .NUM_VECS(2)) dut_s (
        .clk(clk), .reset(reset), .enable(enable), .bus(s.slave)
    );
    matrix_sum_collector #(.IN_WIDTH(16), .VEC_LEN(10), .NUM_VECS(11)) dut_d (
        .clk(clk), .reset(reset), .enable(enable), .bus(d.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [14:0] pk3(input int e2, input int e1, input int e0);
        logic [4:0] a, b, c;
        a = 5'(e2);
        b = 5'(e1);
        c = 5'(e0);
        return {a, b, c};
    endfunction

    task automatic fill_small(input logic [14:0] a, input logic [14:0] b);
        s.inReady = 1'b1;
        s.sumIn   = a;
        tick();
        s.sumIn   = b;
        tick();
        s.inReady = 1'b0;
        chk("s_fill_latency_valid", int'(s.outValid), 1);
        chk("s_fill_collect_ready", int'(s.collectReady), 0);
    endtask

    // mode 0: outAccept held high; mode 1: outAccept pattern 1,0,0 repeating.
    task automatic drain_small(input int mode, input bit poke_last, input int k0, input int k1);
        int k;
        int cyc;
        logic [4:0] ed;
        k = k0;
        cyc = 0;
        while (k < k1 && cyc < 60) begin
            s.outAccept = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
            ed = 5'(exp_d[k]);
            chk("s_valid", int'(s.outValid), 1);
            chk("s_data", int'({27'b0, s.outData}), int'({27'b0, ed}));
            chk("s_row", int'(s.outRow), k / 3);
            chk("s_col", int'(s.outCol), k % 3);
            chk("s_last", int'(s.outLast), (k == 5) ? 1 : 0);
            s.inReady = poke_last && (k == 5);
            s.sumIn   = 15'h7fff;
            if (s.outAccept) k++;
            cyc++;
            tick();
        end
        s.inReady   = 1'b0;
        s.outAccept = 1'b0;
        chk("s_beat_count", k, k1);
    endtask

    task automatic idle_small();
        chk("s_idle_valid", int'(s.outValid), 0);
        chk("s_idle_collect_ready", int'(s.collectReady), 1);
        chk("s_idle_last", int'(s.outLast), 0);
    endtask

    initial begin
        int k;
        int cyc;
        int last_seen;

        reset = 1'b0;
        enable = 1'b1;
        s.inReady = 1'b0; s.sumIn = '0; s.outAccept = 1'b0;
        d.inReady = 1'b0; d.sumIn = '0; d.outAccept = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_collect_ready", int'(s.collectReady), 1);
        chk("rst_valid", int'(s.outValid), 0);
        chk("rst_overflow", int'(s.overflow), 0);
        chk("rst_last", int'(s.outLast), 0);
        chk("rst_d_collect_ready", int'(d.collectReady), 1);
        #2 reset = 1'b1;
        tick();
        chk("post_rst_valid", int'(s.outValid), 0);

        // Basic fill and drain
        exp_d = '{1, 5, -16, -3, 0, 15};
        fill_small(pk3(-16, 5, 1), pk3(15, 0, -3));
        drain_small(0, 1'b0, 0, 6);
        idle_small();

        // Backpressure 1,0,0 pattern
        fill_small(pk3(-16, 5, 1), pk3(15, 0, -3));
        drain_small(1, 1'b0, 0, 6);
        idle_small();
        chk("bp_overflow", int'(s.overflow), 0);

        // Enable freeze mid-fill with strobes
        s.inReady = 1'b1;
        s.sumIn   = pk3(-16, 5, 1);
        tick();
        enable = 1'b0;
        s.sumIn = 15'h2aaa;
        repeat (5) tick();
        chk("frz_fill_collect_ready", int'(s.collectReady), 1);
        chk("frz_fill_valid", int'(s.outValid), 0);
        chk("frz_fill_overflow", int'(s.overflow), 0);
        enable = 1'b1;
        s.sumIn = pk3(15, 0, -3);
        tick();
        s.inReady = 1'b0;
        chk("frz_resume_valid", int'(s.outValid), 1);

        // Enable freeze mid-drain with accept and strobes asserted
        drain_small(0, 1'b0, 0, 2);
        enable = 1'b0;
        s.outAccept = 1'b1;
        s.inReady = 1'b1;
        repeat (5) begin
            tick();
            chk("frz_drain_valid", int'(s.outValid), 1);
            chk("frz_drain_data", int'({27'b0, s.outData}), int'({27'b0, 5'b10000}));
            chk("frz_drain_col", int'(s.outCol), 2);
            chk("frz_drain_overflow", int'(s.overflow), 0);
        end
        enable = 1'b1;
        s.inReady = 1'b0;
        s.outAccept = 1'b0;
        drain_small(0, 1'b0, 2, 6);
        idle_small();

        // Strobe in the same cycle as the last transfer
        drain_small(0, 1'b0, 0, 0);
        fill_small(pk3(-16, 5, 1), pk3(15, 0, -3));
        drain_small(0, 1'b1, 0, 6);
        idle_small();
        chk("ovf_last_set", int'(s.overflow), 1);
        exp_d = '{-8, -1, 7, 12, -5, 3};
        fill_small(pk3(7, -1, -8), pk3(3, -5, 12));
        drain_small(0, 1'b0, 0, 6);
        idle_small();
        chk("ovf_sticky", int'(s.overflow), 1);

        // Async reset mid-drain after 3 beats
        fill_small(pk3(7, -1, -8), pk3(3, -5, 12));
        drain_small(0, 1'b0, 0, 3);
        #2 reset = 1'b0;
        #1;
        chk("arst_valid", int'(s.outValid), 0);
        chk("arst_collect_ready", int'(s.collectReady), 1);
        chk("arst_overflow", int'(s.overflow), 0);
        chk("arst_row", int'(s.outRow), 0);
        #1 reset = 1'b1;
        tick();
        chk("arst_post_valid", int'(s.outValid), 0);
        exp_d = '{1, 5, -16, -3, 0, 15};
        fill_small(pk3(-16, 5, 1), pk3(15, 0, -3));

        // Extra strobe during DRAIN
        s.inReady = 1'b1;
        s.sumIn   = 15'h1234;
        tick();
        s.inReady = 1'b0;
        chk("ovf_drain_set", int'(s.overflow), 1);
        drain_small(0, 1'b0, 0, 6);
        idle_small();
        chk("ovf_drain_sticky", int'(s.overflow), 1);

        // Default-size matrix with random sums and random backpressure
        for (int r = 0; r < 11; r++) begin
            for (int c = 0; c < 10; c++) begin
                sb[r][c] = 17'($urandom);
                dvec[c*17 +: 17] = sb[r][c];
            end
            if (r == 0) begin
                sb[0][0] = 17'h10000;
                dvec[16:0] = 17'h10000;
            end
            if (r == 10) begin
                sb[10][9] = 17'h0ffff;
                dvec[169:153] = 17'h0ffff;
            end
            d.inReady = 1'b1;
            d.sumIn   = dvec;
            tick();
        end
        d.inReady = 1'b0;
        chk("d_fill_latency_valid", int'(d.outValid), 1);
        k = 0;
        cyc = 0;
        last_seen = -1;
        while (k < 110 && cyc < 1000) begin
            d.outAccept = ($urandom_range(0, 3) != 0);
            ed17 = sb[k / 10][k % 10];
            chk("d_valid", int'(d.outValid), 1);
            chk("d_data", int'({15'b0, d.outData}), int'({15'b0, ed17}));
            chk("d_row", int'(d.outRow), k / 10);
            chk("d_col", int'(d.outCol), k % 10);
            chk("d_last", int'(d.outLast), (k == 109) ? 1 : 0);
            if (d.outAccept && d.outLast) last_seen = k;
            if (d.outAccept) k++;
            cyc++;
            tick();
        end
        d.outAccept = 1'b0;
        chk("d_beat_count", k, 110);
        chk("d_last_beat", last_seen, 109);
        chk("d_idle_valid", int'(d.outValid), 0);
        chk("d_idle_collect_ready", int'(d.collectReady), 1);
        chk("d_overflow", int'(d.overflow), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
